// File: rtl/sc_score_pkg.sv
// Shared types and default constants for the Frogger score/high-score unit.
package sc_score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_e;

  localparam int unsigned DEF_SCORE_W     = 8;
  localparam int unsigned DEF_LVL_W       = 3;
  localparam int unsigned DEF_PROG_W      = 5;
  localparam int unsigned DEF_PROG_THRESH = 8;
  localparam int unsigned DEF_PTS_PER_LVL = 1;
  localparam int unsigned DEF_CAP_STEP    = 20;
  localparam int unsigned DEF_BONUS       = 5;

  // Bit positions of the edge-detected event inputs.
  localparam int unsigned EV_NEW_GAME   = 0;
  localparam int unsigned EV_UP_COUNT   = 1;
  localparam int unsigned EV_LEVEL_DONE = 2;

endpackage

// File: rtl/sc_scorekeeper_if.sv
// Signal bundle between the level controller, the scorekeeper and the display formatter.
interface sc_scorekeeper_if #(
  parameter int unsigned SCORE_W = 8,
  parameter int unsigned LVL_W   = 3,
  parameter int unsigned PROG_W  = 5
);
  logic               new_game_n;
  logic               up_count_n;
  logic               level_done_n;
  logic               player_lose_n;
  logic [PROG_W-1:0]  level_progress;
  logic [LVL_W-1:0]   current_lvl;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic               new_high;
  logic               saturated;
  logic               game_over;

  // master: the level controller side that raises events and reads the score.
  modport master (
    output new_game_n, up_count_n, level_done_n, player_lose_n,
    output level_progress, current_lvl,
    input  score, high_score, new_high, saturated, game_over
  );

  modport slave (
    input  new_game_n, up_count_n, level_done_n, player_lose_n,
    input  level_progress, current_lvl,
    output score, high_score, new_high, saturated, game_over
  );
endinterface

// File: rtl/sc_fall_edge_detect.sv
// Falling-edge detector for N active-low event inputs; history resets to the idle (high) level.
module sc_fall_edge_detect #(
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] level_n,
  output logic [N-1:0] fall
);
  logic [N-1:0] hist;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= '1;
    else        hist <= level_n;
  end

  // Zero latency: the event fires in the cycle the low level is first seen.
  assign fall = hist & ~level_n;
endmodule

// File: rtl/sc_scorekeeper.sv
// Frogger score unit: level-scaled capped stepping, level bonus, game FSM and retained high score.
module sc_scorekeeper
  import sc_score_pkg::*;
#(
  parameter int unsigned SCORE_W     = DEF_SCORE_W,
  parameter int unsigned LVL_W       = DEF_LVL_W,
  parameter int unsigned PROG_W      = DEF_PROG_W,
  parameter int unsigned PROG_THRESH = DEF_PROG_THRESH,
  parameter int unsigned PTS_PER_LVL = DEF_PTS_PER_LVL,
  parameter int unsigned CAP_STEP    = DEF_CAP_STEP,
  parameter int unsigned BONUS       = DEF_BONUS
) (
  input  logic               SC_SCOREKEEPER_CLOCK_50,
  input  logic               SC_SCOREKEEPER_RESET_InLow,
  input  logic               SC_SCOREKEEPER_NewGame_InLow,
  input  logic               SC_SCOREKEEPER_upCount_InLow,
  input  logic               SC_SCOREKEEPER_LevelDone_InLow,
  input  logic               SC_SCOREKEEPER_PlayerLose_InLow,
  input  logic [PROG_W-1:0]  SC_SCOREKEEPER_LevelProgress_In,
  input  logic [LVL_W-1:0]   SC_SCOREKEEPER_CurrentLvl_In,
  output logic [SCORE_W-1:0] SC_SCOREKEEPER_Score_OutBus,
  output logic [SCORE_W-1:0] SC_SCOREKEEPER_HighScore_OutBus,
  output logic               SC_SCOREKEEPER_NewHigh_Out,
  output logic               SC_SCOREKEEPER_Saturated_Out,
  output logic               SC_SCOREKEEPER_GameOver_Out
);
  // Wide enough that score + level-scaled increment or bonus never wraps.
  localparam int unsigned W = SCORE_W + LVL_W + 1;
  localparam logic [W-1:0] SCORE_MAX = {{(W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  logic        clk;
  logic        rst_n;
  logic [2:0]  fall;
  logic        ev_new, ev_up, ev_done;

  assign clk   = SC_SCOREKEEPER_CLOCK_50;
  assign rst_n = SC_SCOREKEEPER_RESET_InLow;

  sc_fall_edge_detect #(.N(3)) u_edges (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_n ({SC_SCOREKEEPER_LevelDone_InLow,
               SC_SCOREKEEPER_upCount_InLow,
               SC_SCOREKEEPER_NewGame_InLow}),
    .fall    (fall)
  );

  assign ev_new  = fall[EV_NEW_GAME];
  assign ev_up   = fall[EV_UP_COUNT];
  assign ev_done = fall[EV_LEVEL_DONE];

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d, high_q, high_d;
  logic               new_high_q, new_high_d, sat_q, sat_d;

  logic [W-1:0] lvl_w, score_w, inc, cap_raw, cap, sum1, s1, sum2, s2;
  logic         step_ok, step_clip;

  assign lvl_w   = W'(SC_SCOREKEEPER_CurrentLvl_In);
  assign score_w = W'(score_q);
  assign inc     = lvl_w * W'(PTS_PER_LVL);
  assign cap_raw = lvl_w * W'(CAP_STEP);
  assign cap     = (cap_raw > SCORE_MAX) ? SCORE_MAX : cap_raw;
  assign sum1    = score_w + inc;

  assign step_ok   = ev_up && (SC_SCOREKEEPER_CurrentLvl_In != '0) &&
                     (SC_SCOREKEEPER_LevelProgress_In >= PROG_W'(PROG_THRESH));
  assign step_clip = step_ok && (sum1 > cap);

  // A score already past the cap (via bonuses) is never pulled back down to it.
  assign s1   = !step_ok         ? score_w :
                (score_w >= cap) ? score_w :
                step_clip        ? cap     : sum1;
  assign sum2 = s1 + W'(BONUS);
  assign s2   = !ev_done ? s1 : ((sum2 > SCORE_MAX) ? SCORE_MAX : sum2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      score_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      sat_q      <= sat_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    sat_d      = sat_q;
    if (ev_new) begin
      state_d    = PLAY;
      score_d    = '0;
      new_high_d = 1'b0;
      sat_d      = 1'b0;
    end else begin
      case (state_q)
        PLAY: begin
          if (!SC_SCOREKEEPER_PlayerLose_InLow) begin
            state_d = OVER;
            if (score_q > high_q) begin
              high_d     = score_q;
              new_high_d = 1'b1;
            end
          end else begin
            score_d = s2[SCORE_W-1:0];
            if (step_ok) sat_d = step_clip;
          end
        end
        IDLE, OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign SC_SCOREKEEPER_Score_OutBus     = score_q;
  assign SC_SCOREKEEPER_HighScore_OutBus = high_q;
  assign SC_SCOREKEEPER_NewHigh_Out      = new_high_q;
  assign SC_SCOREKEEPER_Saturated_Out    = sat_q;
  assign SC_SCOREKEEPER_GameOver_Out     = (state_q == OVER);
endmodule

// File: tb/tb_sc_scorekeeper.sv
// Scoreboard bench for sc_scorekeeper: directed scenarios plus random events against a behavioural model.
module tb_sc_scorekeeper;
  localparam int SCORE_W = 8, LVL_W = 3, PROG_W = 5;
  localparam int PROG_THRESH = 8, PTS = 1, CAP_STEP = 20, BONUS = 5;
  localparam int MAX = (1 << SCORE_W) - 1;
  localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2;

  typedef struct {
    int score;
    int high;
    int nh;
    int sat;
    int over;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_scorekeeper_if #(.SCORE_W(SCORE_W), .LVL_W(LVL_W), .PROG_W(PROG_W)) bus ();

  sc_scorekeeper #(
    .SCORE_W(SCORE_W), .LVL_W(LVL_W), .PROG_W(PROG_W), .PROG_THRESH(PROG_THRESH),
    .PTS_PER_LVL(PTS), .CAP_STEP(CAP_STEP), .BONUS(BONUS)
  ) dut (
    .SC_SCOREKEEPER_CLOCK_50         (clk),
    .SC_SCOREKEEPER_RESET_InLow      (rst_n),
    .SC_SCOREKEEPER_NewGame_InLow    (bus.new_game_n),
    .SC_SCOREKEEPER_upCount_InLow    (bus.up_count_n),
    .SC_SCOREKEEPER_LevelDone_InLow  (bus.level_done_n),
    .SC_SCOREKEEPER_PlayerLose_InLow (bus.player_lose_n),
    .SC_SCOREKEEPER_LevelProgress_In (bus.level_progress),
    .SC_SCOREKEEPER_CurrentLvl_In    (bus.current_lvl),
    .SC_SCOREKEEPER_Score_OutBus     (bus.score),
    .SC_SCOREKEEPER_HighScore_OutBus (bus.high_score),
    .SC_SCOREKEEPER_NewHigh_Out      (bus.new_high),
    .SC_SCOREKEEPER_Saturated_Out    (bus.saturated),
    .SC_SCOREKEEPER_GameOver_Out     (bus.game_over)
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  // Reference model state
  int m_state, m_score, m_high, m_nh, m_sat;
  bit p_ng, p_up, p_ld;
  int lvl, prog;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_score = 0; m_high = 0; m_nh = 0; m_sat = 0;
    p_ng = 1'b1; p_up = 1'b1; p_ld = 1'b1;
  endtask

  // Drive one cycle of inputs and push the expected post-edge outputs.
  task automatic apply(input bit ng, input bit up, input bit ld, input bit lose);
    bit e_ng, e_up, e_ld;
    int s, inc, cap;
    exp_t e;
    bus.new_game_n     = ng;
    bus.up_count_n     = up;
    bus.level_done_n   = ld;
    bus.player_lose_n  = lose;
    bus.current_lvl    = LVL_W'(lvl);
    bus.level_progress = PROG_W'(prog);
    e_ng = p_ng && !ng;
    e_up = p_up && !up;
    e_ld = p_ld && !ld;
    p_ng = ng; p_up = up; p_ld = ld;
    if (e_ng) begin
      m_state = M_PLAY; m_score = 0; m_nh = 0; m_sat = 0;
    end else if (m_state == M_PLAY) begin
      if (!lose) begin
        m_state = M_OVER;
        if (m_score > m_high) begin
          m_high = m_score;
          m_nh   = 1;
        end
      end else begin
        s = m_score;
        if (e_up && lvl != 0 && prog >= PROG_THRESH) begin
          inc   = PTS * lvl;
          cap   = (CAP_STEP * lvl > MAX) ? MAX : CAP_STEP * lvl;
          m_sat = (s + inc > cap) ? 1 : 0;
          if (s < cap) s = (s + inc > cap) ? cap : s + inc;
        end
        if (e_ld) s = (s + BONUS > MAX) ? MAX : s + BONUS;
        m_score = s;
      end
    end
    e.score = m_score; e.high = m_high; e.nh = m_nh; e.sat = m_sat;
    e.over  = (m_state == M_OVER) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit ng, input bit up, input bit ld, input bit lose);
    @(negedge clk);
    apply(ng, up, ld, lose);
  endtask

  task automatic idle();
    cyc(1, 1, 1, 1);
  endtask

  task automatic up_pulse();
    cyc(1, 0, 1, 1);
    idle();
  endtask

  task automatic done_pulse();
    cyc(1, 1, 0, 1);
    idle();
  endtask

  // Spot check of all outputs at the edge following the most recent cycle.
  task automatic spot(input string name, input int s, input int h, input int nh,
                      input int sat, input int ov);
    @(posedge clk);
    #2;
    check({name, ".score"},     32'(bus.score),      s);
    check({name, ".high"},      32'(bus.high_score), h);
    check({name, ".new_high"},  32'(bus.new_high),   nh);
    check({name, ".saturated"}, 32'(bus.saturated),  sat);
    check({name, ".game_over"}, 32'(bus.game_over),  ov);
  endtask

  // Scoreboard monitor: compares every cycle for which an expectation was issued.
  exp_t got_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      check("sb.score",     32'(bus.score),      got_e.score);
      check("sb.high",      32'(bus.high_score), got_e.high);
      check("sb.new_high",  32'(bus.new_high),   got_e.nh);
      check("sb.saturated", 32'(bus.saturated),  got_e.sat);
      check("sb.game_over", 32'(bus.game_over),  got_e.over);
    end
  end

  initial begin
    lvl = 2; prog = 10;
    bus.new_game_n = 1; bus.up_count_n = 1; bus.level_done_n = 1; bus.player_lose_n = 1;
    bus.current_lvl = LVL_W'(lvl); bus.level_progress = PROG_W'(prog);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.score",     32'(bus.score),      0);
    check("reset.high",      32'(bus.high_score), 0);
    check("reset.new_high",  32'(bus.new_high),   0);
    check("reset.saturated", 32'(bus.saturated),  0);
    check("reset.game_over", 32'(bus.game_over),  0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 1, 1, 1);
    idle();

    // Start game and step at level 2
    cyc(0, 1, 1, 1); idle();
    cyc(1, 0, 1, 1); spot("step1", 2, 0, 0, 0, 0); idle();
    cyc(1, 0, 1, 1); spot("step2", 4, 0, 0, 0, 0); idle();
    cyc(1, 0, 1, 1); spot("step3", 6, 0, 0, 0, 0); idle();

    // Held low counts once
    repeat (50) cyc(1, 0, 1, 1);
    idle(); spot("held", 8, 0, 0, 0, 0);

    // Progress and level gating
    prog = 7; up_pulse(); spot("prog_gate", 8, 0, 0, 0, 0);
    prog = 10; lvl = 0; up_pulse(); spot("lvl0_gate", 8, 0, 0, 0, 0);

    // Level cap at level 1
    cyc(0, 1, 1, 1); idle();
    lvl = 1;
    repeat (19) up_pulse();
    spot("cap_pre", 19, 0, 0, 0, 0);
    cyc(1, 0, 1, 1); spot("cap_reach", 20, 0, 0, 0, 0); idle();
    cyc(1, 0, 1, 1); spot("cap_clip", 20, 0, 0, 1, 0); idle();
    cyc(1, 1, 0, 1); spot("cap_bonus", 25, 0, 0, 1, 0); idle();

    // Coincident step and bonus at level 3
    lvl = 3;
    repeat (11) up_pulse();
    spot("coinc_pre", 58, 0, 0, 0, 0);
    cyc(1, 0, 0, 1); spot("coinc", 65, 0, 0, 1, 0); idle();

    // Bonus saturation at the score ceiling
    cyc(0, 1, 1, 1); idle();
    up_pulse();
    repeat (50) done_pulse();
    spot("bonus_pre", 253, 0, 0, 0, 0);
    cyc(1, 1, 0, 1); spot("bonus_sat", 255, 0, 0, 0, 0); idle();
    cyc(1, 1, 0, 1); spot("bonus_sat2", 255, 0, 0, 0, 0); idle();

    // Game A ends at 12
    lvl = 2;
    cyc(0, 1, 1, 1); idle();
    repeat (6) up_pulse();
    cyc(1, 1, 1, 0); spot("lose_a", 12, 12, 1, 0, 1); idle();

    // Game B: lose with coincident step at 30
    cyc(0, 1, 1, 1); spot("restart_a", 0, 12, 0, 0, 0); idle();
    repeat (15) up_pulse();
    cyc(1, 0, 1, 0); spot("lose_prio", 30, 30, 1, 0, 1);
    cyc(1, 1, 1, 0); idle();
    cyc(0, 1, 1, 1); spot("restart_b", 0, 30, 0, 0, 0); idle();

    // Reset mid-game at 40, released with upCount held low
    repeat (20) up_pulse();
    spot("pre_reset", 40, 30, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst.score",     32'(bus.score),      0);
    check("async_rst.high",      32'(bus.high_score), 0);
    check("async_rst.new_high",  32'(bus.new_high),   0);
    check("async_rst.saturated", 32'(bus.saturated),  0);
    check("async_rst.game_over", 32'(bus.game_over),  0);
    bus.up_count_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    apply(1, 0, 1, 1);
    repeat (4) cyc(1, 0, 1, 1);
    idle(); spot("rst_release", 0, 0, 0, 0, 0);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) lvl = $urandom_range(7);
      if ($urandom_range(7) == 0) prog = $urandom_range(31);
      cyc(($urandom_range(39) != 0), ($urandom_range(2) != 0),
          ($urandom_range(5) != 0), ($urandom_range(59) != 0));
    end
    idle();
    repeat (2) @(posedge clk);
    #2;
    check("queue_drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
